// File: rtl/fw_cmd_sequencer_if.sv
// Bundle between a request source, the fw command-word interface and the sequencer.
// Request handshake: a transfer happens on the rising clock edge where req_valid and req_ready are both high; req_* must stay stable while req_valid waits for req_ready.
interface fw_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op_code;
  logic [23:0] req_body;
  logic [3:0]  req_done_mask;
  logic [31:0] fw_status;
  logic [31:0] cmd_word;
  logic        cmd_wr;
  logic        rsp_valid;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] rsp_status;

  modport master (
    output req_valid, req_op_code, req_body, req_done_mask, fw_status,
    input  req_ready, cmd_word, cmd_wr, rsp_valid, rsp_error, rsp_timeout, rsp_status
  );

  modport slave (
    input  req_valid, req_op_code, req_body, req_done_mask, fw_status,
    output req_ready, cmd_word, cmd_wr, rsp_valid, rsp_error, rsp_timeout, rsp_status
  );
endinterface

// File: rtl/fw_cmd_sequencer.sv
// Firmware command-word initiator: issue a command, wait for its ack (and optional
// done bits), then issue the status-clear command and report the outcome.
module fw_cmd_sequencer #(
  parameter logic [3:0] DEVICE_ID = 4'h1,
  parameter int         TIMEOUT_W = 16,
  parameter int         ACK_LAT   = 2
) (
  input  logic                 fw_axi_clk,
  input  logic                 fw_rst_n,
  fw_cmd_sequencer_if.slave    bus,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_HOLDOFF   = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_CLEAR     = 3'd5;
  localparam logic [2:0] S_CLR_HOLD  = 3'd6;
  localparam logic [2:0] S_RESP      = 3'd7;

  localparam logic [3:0]  OP_NOOP    = 4'h0;
  localparam logic [3:0]  OP_CLEAR   = 4'hE;
  localparam logic [3:0]  OP_EXEC    = 4'hF;
  localparam logic [31:0] CLEAR_WORD = {DEVICE_ID, OP_CLEAR, 24'h000000};
  localparam logic [3:0]  HOLD_LAST  = 4'(ACK_LAT - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE = TIMEOUT_W'(1);

  logic [2:0]           state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [3:0]           mask_q, mask_d;
  logic [3:0]           hold_cnt_q, hold_cnt_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]          cmd_word_q, cmd_word_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic [31:0]          status_q, status_d;
  logic                 ready_en_q, ready_en_d;

  logic [4:0] ack_idx;
  logic       is_exec;
  logic       ack_hit;
  logic       err_hit;
  logic       done_hit;
  logic       tmo_hit;

  // Ack bit position: ops 1..D map to bit op-1, W_EXECUTE to bit 13.
  always_comb begin
    ack_idx = 5'd0;
    if (op_q == OP_EXEC) begin
      ack_idx = 5'd13;
    end else if (op_q != OP_NOOP && op_q != OP_CLEAR) begin
      ack_idx = {1'b0, op_q - 4'd1};
    end
  end

  assign is_exec  = (op_q == OP_EXEC);
  assign ack_hit  = bus.fw_status[ack_idx];
  assign err_hit  = is_exec && bus.fw_status[31];
  assign done_hit = ((bus.fw_status[17:14] & mask_q) == mask_q);
  assign tmo_hit  = (cfg_timeout != '0) && (wait_cnt_q == cfg_timeout);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mask_d     = mask_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cmd_word_d = cmd_word_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    status_d   = status_q;
    ready_en_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_en_q) begin
          op_d       = bus.req_op_code;
          mask_d     = bus.req_done_mask;
          cmd_word_d = {DEVICE_ID, bus.req_op_code, bus.req_body};
          err_d      = 1'b0;
          tmo_d      = 1'b0;
          status_d   = 32'h0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        hold_cnt_d = 4'd0;
        state_d    = S_HOLDOFF;
      end

      S_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (op_q == OP_NOOP || op_q == OP_CLEAR) begin
            state_d = S_RESP;
          end else begin
            wait_cnt_d = '0;
            state_d    = S_WAIT_ACK;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      // Priority: error, then ack, then timeout, so an ack on the timeout cycle wins.
      S_WAIT_ACK: begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
        if (err_hit) begin
          err_d    = 1'b1;
          status_d = bus.fw_status;
          state_d  = S_CLEAR;
        end else if (ack_hit) begin
          status_d = bus.fw_status;
          if (is_exec && mask_q != 4'h0) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          status_d = bus.fw_status;
          state_d  = S_CLEAR;
        end
      end

      S_WAIT_DONE: begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
        if (bus.fw_status[31]) begin
          err_d    = 1'b1;
          status_d = bus.fw_status;
          state_d  = S_CLEAR;
        end else if (done_hit) begin
          status_d = bus.fw_status;
          state_d  = S_CLEAR;
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          status_d = bus.fw_status;
          state_d  = S_CLEAR;
        end
      end

      S_CLEAR: begin
        hold_cnt_d = 4'd0;
        state_d    = S_CLR_HOLD;
      end

      S_CLR_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RESP;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // cmd_word is a register, so the clear word is loaded on the way into CLEAR.
    if (state_d == S_CLEAR && state_q != S_CLEAR) begin
      cmd_word_d = CLEAR_WORD;
    end
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 4'h0;
      mask_q     <= 4'h0;
      hold_cnt_q <= 4'd0;
      wait_cnt_q <= '0;
      cmd_word_q <= 32'h0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      status_q   <= 32'h0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_word_q <= cmd_word_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      status_q   <= status_d;
      ready_en_q <= ready_en_d;
    end
  end

  // ready_en_q keeps req_ready low until the first clock after reset release.
  assign bus.req_ready   = ready_en_q && (state_q == S_IDLE);
  assign bus.cmd_word    = cmd_word_q;
  assign bus.cmd_wr      = (state_q == S_ISSUE) || (state_q == S_CLEAR);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_error   = err_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.rsp_status  = status_q;
  assign busy            = (state_q != S_IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fw_cmd_sequencer.sv
// Bench for fw_cmd_sequencer: a vector table of requests with firmware status
// timelines, plus hand-written reset sequences, checked against a scoreboard.
module tb_fw_cmd_sequencer;

  localparam int          ACK_LAT = 2;
  localparam int          WAIT1   = ACK_LAT + 1;  // first WAIT_ACK cycle, counted from issue strobe
  localparam logic [31:0] CLR_W   = 32'h1E000000;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_timeout;
  logic        busy;
  logic [2:0]  dbg_state;

  fw_cmd_sequencer_if bus ();

  fw_cmd_sequencer #(.DEVICE_ID(4'h1), .TIMEOUT_W(16), .ACK_LAT(ACK_LAT)) dut (
    .fw_axi_clk (clk),
    .fw_rst_n   (rst_n),
    .bus        (bus),
    .cfg_timeout(cfg_timeout),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [23:0] body;
    logic [3:0]  mask;
    logic [15:0] tmo;
    int          ack_c;
    logic [31:0] ack_bits;
    int          done_c;
    logic [31:0] done_bits;
    int          clr_c;
    int          rsp_c;
    logic        err;
    logic        tmo_f;
    logic [31:0] status;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  logic [31:0] exp_q[$];
  logic [33:0] rsp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [23:0] body,
                              input logic [3:0] mask, input logic [15:0] tmo,
                              input int ack_c, input logic [31:0] ack_bits,
                              input int done_c, input logic [31:0] done_bits,
                              input int clr_c, input int rsp_c, input logic err,
                              input logic tmo_f, input logic [31:0] status);
    vec_t v;
    v.op = op; v.body = body; v.mask = mask; v.tmo = tmo;
    v.ack_c = ack_c; v.ack_bits = ack_bits; v.done_c = done_c; v.done_bits = done_bits;
    v.clr_c = clr_c; v.rsp_c = rsp_c; v.err = err; v.tmo_f = tmo_f; v.status = status;
    return v;
  endfunction

  // scoreboard pop on every strobe / response pulse
  task automatic observe();
    logic [31:0] w;
    logic [33:0] r;
    if (bus.cmd_wr) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_unexpected actual=%0h expected=none", bus.cmd_word);
      end else begin
        w = exp_q.pop_front();
        chk("cmd_word", {32'h0, bus.cmd_word}, {32'h0, w});
      end
    end
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected actual=%0h expected=none", bus.rsp_status);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_fields", {30'h0, bus.rsp_error, bus.rsp_timeout, bus.rsp_status}, {30'h0, r});
      end
    end
  endtask

  // Returns at the negedge of the cycle after the handshake (the expected issue cycle).
  task automatic start_req(input logic [3:0] op, input logic [23:0] body,
                           input logic [3:0] mask, output bit ok);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op_code = op;
    bus.req_body = body;
    bus.req_done_mask = mask;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_ready_wait actual=0 expected=1");
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c, clr_seen, rsp_seen;
    bit ok;
    bus.fw_status = 32'h0;
    cfg_timeout = v.tmo;
    exp_q.push_back({4'h1, v.op, v.body});
    if (v.clr_c >= 0) exp_q.push_back(CLR_W);
    rsp_q.push_back({v.err, v.tmo_f, v.status});
    start_req(v.op, v.body, v.mask, ok);
    if (!ok) begin
      exp_q.delete();
      rsp_q.delete();
      return;
    end
    chk($sformatf("issue_wr_v%0d", idx), {63'h0, bus.cmd_wr}, 64'h1);
    chk($sformatf("busy_v%0d", idx), {63'h0, busy}, 64'h1);
    c = 0; clr_seen = -1; rsp_seen = -1;
    while (rsp_seen < 0 && c < 200) begin
      if (c == v.ack_c) bus.fw_status = bus.fw_status | v.ack_bits;
      if (c == v.done_c) bus.fw_status = bus.fw_status | v.done_bits;
      observe();
      if (bus.cmd_wr && c > 0) begin
        clr_seen = c;
        bus.fw_status = 32'h0;
      end
      if (bus.rsp_valid) rsp_seen = c;
      if (rsp_seen < 0) begin
        @(negedge clk);
        c++;
      end
    end
    chk($sformatf("clr_cycle_v%0d", idx), 64'(clr_seen), 64'(v.clr_c));
    chk($sformatf("rsp_cycle_v%0d", idx), 64'(rsp_seen), 64'(v.rsp_c));
    @(negedge clk);
    // response fields hold in IDLE until the next handshake
    repeat (2) @(negedge clk);
    chk($sformatf("hold_v%0d", idx), {30'h0, bus.rsp_error, bus.rsp_timeout, bus.rsp_status},
        {30'h0, v.err, v.tmo_f, v.status});
    chk($sformatf("idle_v%0d", idx), {62'h0, busy, bus.req_ready}, 64'h1);
  endtask

  initial begin
    int ex;
    logic [3:0] rop;
    int rack;
    bit ok;

    // table: op body mask tmo ack_c ack_bits done_c done_bits clr rsp err tmo status
    vecs[0]  = mk(4'h2, 24'h00A50C, 4'h0, 16'd0,  3, 32'h00000002, -1, 32'h0, 4, 7, 0, 0, 32'h00000002);
    vecs[1]  = mk(4'hF, 24'h000111, 4'h2, 16'd0,  5, 32'h00006000, 40, 32'h00008000, 41, 44, 0, 0, 32'h0000E000);
    vecs[2]  = mk(4'h3, 24'h000222, 4'h0, 16'd16, -1, 32'h0, -1, 32'h0, WAIT1 + 17, WAIT1 + 20, 0, 1, 32'h0);
    vecs[3]  = mk(4'hF, 24'h000333, 4'h2, 16'd0,  4, 32'h80002000, -1, 32'h0, 5, 8, 1, 0, 32'h80002000);
    vecs[4]  = mk(4'h0, 24'h000000, 4'h0, 16'd0, -1, 32'h0, -1, 32'h0, -1, ACK_LAT + 1, 0, 0, 32'h0);
    vecs[5]  = mk(4'hE, 24'h000000, 4'h0, 16'd0, -1, 32'h0, -1, 32'h0, -1, ACK_LAT + 1, 0, 0, 32'h0);
    vecs[6]  = mk(4'hD, 24'h123456, 4'h0, 16'd16, 10, 32'h00001000, -1, 32'h0, 11, 14, 0, 0, 32'h00001000);
    vecs[7]  = mk(4'h1, 24'h000777, 4'h0, 16'd5,  8, 32'h00000001, -1, 32'h0, 9, 12, 0, 0, 32'h00000001);
    vecs[8]  = mk(4'hF, 24'h000888, 4'hF, 16'd4,  3, 32'h00002000, 5, 32'h0000C000, 9, 12, 0, 1, 32'h0000E000);
    vecs[9]  = mk(4'hF, 24'h000999, 4'h1, 16'd0,  3, 32'h00002000, 6, 32'h80000000, 7, 10, 1, 0, 32'h80002000);
    vecs[10] = mk(4'hF, 24'h000AAA, 4'h0, 16'd0,  5, 32'h00002000, -1, 32'h0, 6, 9, 0, 0, 32'h00002000);
    vecs[11] = mk(4'h6, 24'h000BBB, 4'h0, 16'd0,  1, 32'h00000020, -1, 32'h0, 4, 7, 0, 0, 32'h00000020);
    vecs[12] = mk(4'h2, 24'h000CCC, 4'h0, 16'd0,  3, 32'h80000002, -1, 32'h0, 4, 7, 0, 0, 32'h80000002);
    vecs[13] = mk(4'hF, 24'h000DDD, 4'h2, 16'd0,  4, 32'h0000A000, -1, 32'h0, 6, 9, 0, 0, 32'h0000A000);
    for (int i = 14; i < NV; i++) begin
      rop  = 4'($urandom_range(1, 13));
      rack = $urandom_range(1, 12);
      ex   = (rack > WAIT1) ? rack : WAIT1;
      vecs[i] = mk(rop, 24'($urandom_range(0, 24'hFFFFFF)), 4'h0, 16'd0, rack,
                   32'h1 << (rop - 4'd1), -1, 32'h0, ex + 1, ex + 2 + ACK_LAT, 0, 0,
                   32'h1 << (rop - 4'd1));
    end

    rst_n = 1'b0;
    cfg_timeout = 16'd0;
    bus.req_valid = 1'b0;
    bus.req_op_code = 4'h0;
    bus.req_body = 24'h0;
    bus.req_done_mask = 4'h0;
    bus.fw_status = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.req_ready, bus.cmd_wr, busy, bus.rsp_valid, bus.rsp_error,
                          bus.rsp_timeout, bus.cmd_word, bus.rsp_status[25:0]}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_clk", {63'h0, bus.req_ready}, 64'h0);
    @(negedge clk);
    chk("ready_after_clk", {63'h0, bus.req_ready}, 64'h1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // reset pulse while waiting for done bits
    exp_q.push_back(32'h1F0ABCDE);
    start_req(4'hF, 24'h0ABCDE, 4'h2, ok);
    for (int c = 0; c < 10 && ok; c++) begin
      if (c == 3) bus.fw_status = 32'h00002000;
      observe();
      @(negedge clk);
    end
    chk("pre_reset_state", {61'h0, dbg_state}, 64'd4);
    chk("pre_reset_status", {32'h0, bus.rsp_status}, 64'h2000);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {bus.req_ready, bus.cmd_wr, busy, bus.rsp_valid, bus.rsp_error,
                          bus.rsp_timeout, 3'(dbg_state), bus.cmd_word}, 64'h0);
    chk("abort_status", {32'h0, bus.rsp_status}, 64'h0);
    bus.fw_status = 32'h0;
    @(negedge clk);
    chk("abort_no_strobe", {62'h0, bus.cmd_wr, busy}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_low", {63'h0, bus.req_ready}, 64'h0);
    @(negedge clk);
    chk("abort_ready_high", {63'h0, bus.req_ready}, 64'h1);
    run_vec(vecs[0], 100);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
